// File: rtl/dmem_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_if
//  Brief    : Bundle of the three requester ports (external loader, scalar
//             LSU, vector LSU) and the single-port data memory side.
//             slave  = arbiter view, master = requesters/memory view.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 5
);
  // external loader (write only)
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ready;
  // scalar load/store unit
  logic              sc_req;
  logic              sc_we;
  logic [ADDR_W-1:0] sc_addr;
  logic [DATA_W-1:0] sc_wdata;
  logic              sc_gnt;
  logic              sc_rvalid;
  logic [DATA_W-1:0] sc_rdata;
  // vector load/store unit
  logic              vx_req;
  logic              vx_we;
  logic [ADDR_W-1:0] vx_addr;
  logic [DATA_W-1:0] vx_wdata;
  logic [LEN_W-1:0]  vx_len;
  logic              vx_gnt;
  logic              vx_rvalid;
  logic [DATA_W-1:0] vx_rdata;
  // data memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              busy;

  modport slave (
    input  ext_we, ext_addr, ext_wdata,
    input  sc_req, sc_we, sc_addr, sc_wdata,
    input  vx_req, vx_we, vx_addr, vx_wdata, vx_len,
    input  mem_rdata,
    output ext_ready,
    output sc_gnt, sc_rvalid, sc_rdata,
    output vx_gnt, vx_rvalid, vx_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output ext_we, ext_addr, ext_wdata,
    output sc_req, sc_we, sc_addr, sc_wdata,
    output vx_req, vx_we, vx_addr, vx_wdata, vx_len,
    output mem_rdata,
    input  ext_ready,
    input  sc_gnt, sc_rvalid, sc_rdata,
    input  vx_gnt, vx_rvalid, vx_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Brief    : Shares one single-port data memory between the external loader,
//             the scalar LSU and the vector LSU. One access per cycle,
//             ext > round-robin(scalar, vector), vector bursts hold a lock,
//             read data is steered back via a tag pipeline of RD_LAT stages.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 15,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_port_if.slave  bus
);

  localparam int               c_len_w   = $clog2(MAX_BURST + 1);
  localparam logic [c_len_w-1:0] c_len_one = c_len_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SC   = 2'd1,
    TAG_VX   = 2'd2
  } tag_t;

  state_t             r_state, w_state_nxt;
  logic               r_rr_vx, w_rr_vx_nxt;      // 1: vector wins the next sc/vx tie
  logic [c_len_w-1:0] r_beats_left, w_beats_left_nxt;
  tag_t               r_tag [RD_LAT];

  logic               w_ext_win, w_sc_win, w_vx_win;
  logic               w_ext_gnt, w_sc_gnt, w_vx_gnt;
  logic               w_mem_en, w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;
  tag_t               w_issue_tag;
  logic               w_tags_live;
  logic               w_sc_rvalid, w_vx_rvalid;

  // State, round-robin pointer and burst beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_vx      <= 1'b0;
      r_beats_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_vx      <= w_rr_vx_nxt;
      r_beats_left <= w_beats_left_nxt;
    end
  end

  // Arbitration decision and next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_rr_vx_nxt      = r_rr_vx;
    w_beats_left_nxt = r_beats_left;
    w_ext_win        = 1'b0;
    w_sc_win         = 1'b0;
    w_vx_win         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.ext_we) begin
          w_ext_win = 1'b1;
        end else if (bus.sc_req && bus.vx_req) begin
          w_vx_win = r_rr_vx;
          w_sc_win = !r_rr_vx;
        end else begin
          w_sc_win = bus.sc_req;
          w_vx_win = bus.vx_req;
        end
        if (w_sc_win) begin
          w_rr_vx_nxt = 1'b1;
        end
        if (w_vx_win) begin
          w_rr_vx_nxt = 1'b0;
          // A length of 0 or 1 is a single beat and never locks the port
          if (bus.vx_len > c_len_one) begin
            w_beats_left_nxt = bus.vx_len - c_len_one;
            w_state_nxt      = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        // Gaps in vx_req stall the burst but keep the lock
        w_vx_win = bus.vx_req;
        if (bus.vx_req) begin
          w_beats_left_nxt = r_beats_left - c_len_one;
          if (r_beats_left == c_len_one) begin
            w_state_nxt = ST_IDLE;
            w_rr_vx_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Every output is held at 0 while reset is asserted
  assign w_ext_gnt = w_ext_win && !rst;
  assign w_sc_gnt  = w_sc_win  && !rst;
  assign w_vx_gnt  = w_vx_win  && !rst;

  // Memory request mux from the winning requester, plus the read tag to issue
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_issue_tag = TAG_NONE;
    if (w_ext_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = 1'b1;
      w_mem_addr  = bus.ext_addr;
      w_mem_wdata = bus.ext_wdata;
    end else if (w_sc_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.sc_we;
      w_mem_addr  = bus.sc_addr;
      w_mem_wdata = bus.sc_wdata;
      w_issue_tag = bus.sc_we ? TAG_NONE : TAG_SC;
    end else if (w_vx_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.vx_we;
      w_mem_addr  = bus.vx_addr;
      w_mem_wdata = bus.vx_wdata;
      w_issue_tag = bus.vx_we ? TAG_NONE : TAG_VX;
    end
  end

  // Read-return tag shift register, one stage per cycle of memory latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag[i] <= TAG_NONE;
      end
    end else begin
      r_tag[0] <= w_issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Any read still travelling through the tag pipeline keeps busy high
  always_comb begin
    w_tags_live = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (r_tag[i] != TAG_NONE) begin
        w_tags_live = 1'b1;
      end
    end
  end

  assign w_sc_rvalid = (r_tag[RD_LAT-1] == TAG_SC);
  assign w_vx_rvalid = (r_tag[RD_LAT-1] == TAG_VX);

  assign bus.ext_ready = w_ext_gnt;
  assign bus.sc_gnt    = w_sc_gnt;
  assign bus.vx_gnt    = w_vx_gnt;
  assign bus.sc_rvalid = w_sc_rvalid;
  assign bus.vx_rvalid = w_vx_rvalid;
  assign bus.sc_rdata  = w_sc_rvalid ? bus.mem_rdata : '0;
  assign bus.vx_rdata  = w_vx_rvalid ? bus.mem_rdata : '0;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.busy      = (r_state == ST_BURST) || w_tags_live;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Brief    : Two arbiters (RD_LAT=1 and RD_LAT=3) share one stimulus; a
//             queue-based reference model predicts grants, memory requests
//             and read returns. Directed table, hand sequences, random run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 15;
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = $clog2(MAX_BURST + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // requester-side stimulus
  logic              ext_we = 0;
  logic [ADDR_W-1:0] ext_addr = '0;
  logic [DATA_W-1:0] ext_wdata = '0;
  logic              sc_req = 0, sc_we = 0;
  logic [ADDR_W-1:0] sc_addr = '0;
  logic [DATA_W-1:0] sc_wdata = '0;
  logic              vx_req = 0, vx_we = 0;
  logic [ADDR_W-1:0] vx_addr = '0;
  logic [DATA_W-1:0] vx_wdata = '0;
  logic [LEN_W-1:0]  vx_len = '0;

  dmem_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus1 ();
  dmem_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus3 ();

  assign bus1.ext_we = ext_we;   assign bus3.ext_we = ext_we;
  assign bus1.ext_addr = ext_addr; assign bus3.ext_addr = ext_addr;
  assign bus1.ext_wdata = ext_wdata; assign bus3.ext_wdata = ext_wdata;
  assign bus1.sc_req = sc_req;   assign bus3.sc_req = sc_req;
  assign bus1.sc_we = sc_we;     assign bus3.sc_we = sc_we;
  assign bus1.sc_addr = sc_addr; assign bus3.sc_addr = sc_addr;
  assign bus1.sc_wdata = sc_wdata; assign bus3.sc_wdata = sc_wdata;
  assign bus1.vx_req = vx_req;   assign bus3.vx_req = vx_req;
  assign bus1.vx_we = vx_we;     assign bus3.vx_we = vx_we;
  assign bus1.vx_addr = vx_addr; assign bus3.vx_addr = vx_addr;
  assign bus1.vx_wdata = vx_wdata; assign bus3.vx_wdata = vx_wdata;
  assign bus1.vx_len = vx_len;   assign bus3.vx_len = vx_len;

  dmem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .RD_LAT(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .RD_LAT(3))
    dut3 (.clk(clk), .rst(rst), .bus(bus3));

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return {17'h1A5A5, a} ^ 32'h0F0F_0000;
  endfunction

  // Behavioural memory driven by the RD_LAT=1 arbiter (both issue identically)
  bit [DATA_W-1:0] mem [32768];
  bit              mem_wr [32768];
  logic [DATA_W-1:0] rd_pipe [3];
  always @(posedge clk) begin
    if (bus1.mem_en && bus1.mem_we) begin
      mem[bus1.mem_addr]    <= bus1.mem_wdata;
      mem_wr[bus1.mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= mem_wr[bus1.mem_addr] ? mem[bus1.mem_addr] : init_val(bus1.mem_addr);
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign bus1.mem_rdata = rd_pipe[0];
  assign bus3.mem_rdata = rd_pipe[2];

  // ---------------- reference model ----------------
  typedef struct { int due; bit is_vx; logic [DATA_W-1:0] data; } ret_t;
  ret_t q1[$];
  ret_t q3[$];
  int   m_left   = 0;     // vector beats still owed by the locked burst
  bit   m_fav_vx = 0;     // next sc/vx tie goes to the vector unit
  bit [DATA_W-1:0] m_mem [32768];
  bit              m_wr  [32768];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic inputs_idle();
    ext_we = 0; sc_req = 0; sc_we = 0; vx_req = 0; vx_we = 0; vx_len = '0;
  endtask

  // One clock cycle: inputs are already applied; predict, compare, advance.
  task automatic run_cycle(output bit g_ext, output bit g_sc, output bit g_vx);
    bit e_en, e_we, e1s, e1v, e3s, e3v;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd, e1d, e3d, rd;
    int len;
    #1;
    g_ext = 0; g_sc = 0; g_vx = 0;
    if (m_left > 0) g_vx = vx_req;
    else if (ext_we) g_ext = 1;
    else if (sc_req && vx_req) begin
      if (m_fav_vx) g_vx = 1; else g_sc = 1;
    end else begin
      g_sc = sc_req; g_vx = vx_req;
    end
    e_en = g_ext | g_sc | g_vx;
    e_we = 0; e_addr = '0; e_wd = '0;
    if (g_ext)     begin e_we = 1;     e_addr = ext_addr; e_wd = ext_wdata; end
    else if (g_sc) begin e_we = sc_we; e_addr = sc_addr;  e_wd = sc_wdata;  end
    else if (g_vx) begin e_we = vx_we; e_addr = vx_addr;  e_wd = vx_wdata;  end

    check("grants_lat1", {bus1.ext_ready, bus1.sc_gnt, bus1.vx_gnt, bus1.mem_en}, {g_ext, g_sc, g_vx, e_en});
    check("grants_lat3", {bus3.ext_ready, bus3.sc_gnt, bus3.vx_gnt, bus3.mem_en}, {g_ext, g_sc, g_vx, e_en});
    if (e_en) begin
      check("memreq_lat1", {bus1.mem_we, bus1.mem_addr, bus1.mem_wdata}, {e_we, e_addr, e_wd});
      check("memreq_lat3", {bus3.mem_we, bus3.mem_addr, bus3.mem_wdata}, {e_we, e_addr, e_wd});
    end
    check("busy_lat1", bus1.busy, (m_left > 0) || (q1.size() > 0));
    check("busy_lat3", bus3.busy, (m_left > 0) || (q3.size() > 0));

    e1s = 0; e1v = 0; e1d = '0; e3s = 0; e3v = 0; e3d = '0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e1v = q1[0].is_vx; e1s = !q1[0].is_vx; e1d = q1[0].data; void'(q1.pop_front());
    end
    if (q3.size() > 0 && q3[0].due == cyc) begin
      e3v = q3[0].is_vx; e3s = !q3[0].is_vx; e3d = q3[0].data; void'(q3.pop_front());
    end
    check("rvalid_lat1", {bus1.sc_rvalid, bus1.vx_rvalid}, {e1s, e1v});
    check("rvalid_lat3", {bus3.sc_rvalid, bus3.vx_rvalid}, {e3s, e3v});
    if (e1s) check("sc_rdata_lat1", bus1.sc_rdata, e1d);
    if (e1v) check("vx_rdata_lat1", bus1.vx_rdata, e1d);
    if (e3s) check("sc_rdata_lat3", bus3.sc_rdata, e3d);
    if (e3v) check("vx_rdata_lat3", bus3.vx_rdata, e3d);

    // model state update for the access issued this cycle
    if (e_en && !e_we) begin
      rd = m_wr[e_addr] ? m_mem[e_addr] : init_val(e_addr);
      q1.push_back('{due: cyc + 1, is_vx: g_vx, data: rd});
      q3.push_back('{due: cyc + 3, is_vx: g_vx, data: rd});
    end
    if (e_en && e_we) begin
      m_mem[e_addr] = e_wd; m_wr[e_addr] = 1'b1;
    end
    if (g_sc) m_fav_vx = 1;
    if (g_vx) begin
      if (m_left > 0) m_left--;
      else begin
        len = (vx_len == 0) ? 1 : int'(vx_len);
        m_left = len - 1;
      end
      m_fav_vx = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset at a negedge with whatever inputs are live; outputs must drop at once.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    #1;
    check("rst_ctrl_lat1", {bus1.ext_ready, bus1.sc_gnt, bus1.vx_gnt, bus1.sc_rvalid, bus1.vx_rvalid,
                            bus1.mem_en, bus1.mem_we, bus1.busy}, 8'h00);
    check("rst_ctrl_lat3", {bus3.ext_ready, bus3.sc_gnt, bus3.vx_gnt, bus3.sc_rvalid, bus3.vx_rvalid,
                            bus3.mem_en, bus3.mem_we, bus3.busy}, 8'h00);
    check("rst_data_lat1", {bus1.mem_addr, bus1.mem_wdata} | {15'h0, bus1.sc_rdata | bus1.vx_rdata}, 0);
    repeat (2) @(posedge clk);
    q1.delete(); q3.delete(); m_left = 0; m_fav_vx = 0;
    inputs_idle();
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    bit ext; bit sc; bit vx; logic [LEN_W-1:0] len;
    bit e_ext; bit e_sc; bit e_vx;
  } vec_t;

  function automatic vec_t mkv(bit ext, bit sc, bit vx, int len, bit e_ext, bit e_sc, bit e_vx);
    vec_t v;
    v.ext = ext; v.sc = sc; v.vx = vx; v.len = LEN_W'(len);
    v.e_ext = e_ext; v.e_sc = e_sc; v.e_vx = e_vx;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    bit ge, gs, gv;
    int vx_todo, vx_idx, guard;
    logic [ADDR_W-1:0] vx_base;

    // sc/vx alternation, burst lock with gap, ext priority, len 0
    tbl[0]  = mkv(0,1,1,1, 0,1,0);
    tbl[1]  = mkv(0,1,1,1, 0,0,1);
    tbl[2]  = mkv(0,1,1,1, 0,1,0);
    tbl[3]  = mkv(0,1,1,1, 0,0,1);
    tbl[4]  = mkv(0,0,1,4, 0,0,1);
    tbl[5]  = mkv(1,1,1,4, 0,0,1);
    tbl[6]  = mkv(1,1,0,4, 0,0,0);
    tbl[7]  = mkv(1,1,0,4, 0,0,0);
    tbl[8]  = mkv(1,1,1,4, 0,0,1);
    tbl[9]  = mkv(1,1,1,4, 0,0,1);
    tbl[10] = mkv(1,1,0,4, 1,0,0);
    tbl[11] = mkv(0,1,0,4, 0,1,0);
    tbl[12] = mkv(1,1,0,1, 1,0,0);
    tbl[13] = mkv(0,1,0,1, 0,1,0);
    tbl[14] = mkv(0,0,1,0, 0,0,1);
    tbl[15] = mkv(0,1,1,1, 0,1,0);
    tbl[16] = mkv(0,1,1,1, 0,0,1);

    apply_reset();

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      ext_we = tbl[i].ext; ext_addr = ADDR_W'(15'h50 + i); ext_wdata = 32'h1111 * i;
      sc_req = tbl[i].sc; sc_we = 0; sc_addr = 15'h60;
      vx_req = tbl[i].vx; vx_we = 0; vx_addr = ADDR_W'(15'h70 + i); vx_len = tbl[i].len;
      #1;
      check($sformatf("tbl_row%0d", i), {bus1.ext_ready, bus1.sc_gnt, bus1.vx_gnt},
            {tbl[i].e_ext, tbl[i].e_sc, tbl[i].e_vx});
      run_cycle(ge, gs, gv);
    end

    // DEADBEEF scalar read with RD_LAT=1
    @(negedge clk); inputs_idle(); ext_we = 1; ext_addr = 15'h10; ext_wdata = 32'hDEADBEEF;
    run_cycle(ge, gs, gv);
    @(negedge clk); inputs_idle(); sc_req = 1; sc_addr = 15'h10;
    #1; check("hand_sc_gnt_same_cycle", bus1.sc_gnt, 1'b1);
    run_cycle(ge, gs, gv);
    @(negedge clk); inputs_idle();
    #1; check("hand_sc_rdata_lat1", {bus1.sc_rvalid, bus1.sc_rdata}, {1'b1, 32'hDEADBEEF});
    run_cycle(ge, gs, gv);

    // RD_LAT=3 back-to-back sc, vx, sc reads
    @(negedge clk); inputs_idle(); ext_we = 1; ext_addr = 15'h20; ext_wdata = 32'hCAFEF00D;
    run_cycle(ge, gs, gv);
    @(negedge clk); inputs_idle(); ext_we = 1; ext_addr = 15'h30; ext_wdata = 32'h12345678;
    run_cycle(ge, gs, gv);
    for (int i = 0; i < 4; i++) begin @(negedge clk); inputs_idle(); run_cycle(ge, gs, gv); end
    @(negedge clk); inputs_idle(); sc_req = 1; sc_addr = 15'h10; run_cycle(ge, gs, gv);
    @(negedge clk); inputs_idle(); vx_req = 1; vx_addr = 15'h20; vx_len = 1; run_cycle(ge, gs, gv);
    @(negedge clk); inputs_idle(); sc_req = 1; sc_addr = 15'h30; run_cycle(ge, gs, gv);
    @(negedge clk); inputs_idle();
    #1; check("hand_lat3_c3", {bus3.sc_rvalid, bus3.vx_rvalid, bus3.sc_rdata}, {2'b10, 32'hDEADBEEF});
    run_cycle(ge, gs, gv);
    @(negedge clk);
    #1; check("hand_lat3_c4", {bus3.sc_rvalid, bus3.vx_rvalid, bus3.vx_rdata}, {2'b01, 32'hCAFEF00D});
    run_cycle(ge, gs, gv);
    @(negedge clk);
    #1; check("hand_lat3_c5", {bus3.sc_rvalid, bus3.vx_rvalid, bus3.sc_rdata}, {2'b10, 32'h12345678});
    run_cycle(ge, gs, gv);

    // randomized traffic; requesters hold their request until granted
    vx_todo = 0; vx_idx = 0; vx_base = '0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (!ext_we && $urandom_range(0, 5) == 0) begin
        ext_we = 1; ext_addr = ADDR_W'($urandom_range(0, 63)); ext_wdata = $urandom;
      end
      if (!sc_req && $urandom_range(0, 1) == 0) begin
        sc_req = 1; sc_we = 1'($urandom_range(0, 1));
        sc_addr = ADDR_W'($urandom_range(0, 63)); sc_wdata = $urandom;
      end
      if (!vx_req) begin
        if (vx_todo == 0 && $urandom_range(0, 2) == 0) begin
          vx_len = LEN_W'($urandom_range(0, 5));
          vx_todo = (vx_len == 0) ? 1 : int'(vx_len);
          vx_we = 1'($urandom_range(0, 1));
          vx_base = ADDR_W'($urandom_range(0, 56)); vx_idx = 0;
        end
        if (vx_todo > 0 && $urandom_range(0, 3) != 0) begin
          vx_req = 1; vx_addr = vx_base + ADDR_W'(vx_idx); vx_wdata = $urandom;
        end
      end
      run_cycle(ge, gs, gv);
      if (ge) ext_we = 0;
      if (gs) sc_req = 0;
      if (gv) begin vx_req = 0; vx_todo--; vx_idx++; end
    end
    // finish any burst still open, then let reads drain
    guard = 0;
    while (vx_todo > 0 && guard < 40) begin
      @(negedge clk); ext_we = 0; sc_req = 0; vx_req = 1; vx_addr = vx_base + ADDR_W'(vx_idx);
      run_cycle(ge, gs, gv);
      if (gv) begin vx_todo--; vx_idx++; end
      guard++;
    end
    check("drain_burst", vx_todo, 0);
    for (int i = 0; i < 5; i++) begin @(negedge clk); inputs_idle(); run_cycle(ge, gs, gv); end

    // reset during beat 2 of a 4-beat read burst, with reads in flight
    @(negedge clk); inputs_idle(); vx_req = 1; vx_we = 0; vx_len = 4; vx_addr = 15'h40;
    run_cycle(ge, gs, gv);
    @(negedge clk); vx_addr = 15'h41; run_cycle(ge, gs, gv);
    check("hand_burst_busy", bus3.busy, 1'b1);
    vx_addr = 15'h42; sc_req = 1; sc_addr = 15'h11; ext_we = 1; ext_addr = 15'h12;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); inputs_idle();
      #1; check("hand_no_rvalid_after_rst",
                {bus1.sc_rvalid, bus1.vx_rvalid, bus3.sc_rvalid, bus3.vx_rvalid, bus3.busy}, 5'b0);
      run_cycle(ge, gs, gv);
    end
    @(negedge clk); inputs_idle(); sc_req = 1; sc_addr = 15'h10;
    #1; check("hand_sc_gnt_after_rst", {bus1.sc_gnt, bus3.sc_gnt}, 2'b11);
    run_cycle(ge, gs, gv);
    @(negedge clk); inputs_idle(); run_cycle(ge, gs, gv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
